// File: rtl/token_pkg.sv
// Shared definitions for the token-rate measurement path: FSM encoding and
// the default window length used by the counter and the halving stage's bench.
package token_pkg;

    localparam int DEFAULT_WINDOW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Count field wide enough to hold 0..window inclusive.
    function automatic int cnt_width(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/token_window_counter_if.sv
// Serial token input, run control and the valid/ready result channel of
// token_window_counter. The master side feeds tokens and accepts results.
interface token_window_counter_if #(
    parameter int CNT_W = 4
);

    // Handshake: a result transfers on every cycle where out_valid & out_ready
    // are both high; out_count is held stable while out_valid=1 and out_ready=0.
    logic             a;
    logic             start;
    logic             stop;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             overflow;
    token_pkg::state_t state;

    modport master (
        output a, start, stop, out_ready,
        input  out_count, out_valid, overflow, state
    );

    modport slave (
        input  a, start, stop, out_ready,
        output out_count, out_valid, overflow, state
    );

endinterface

// File: rtl/halve_tokens.sv
// Upstream token-halving stage: passes every second '1' token of the serial
// stream through unchanged in timing and suppresses the others.
module halve_tokens (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic half
);

    logic phase;

    assign half = a & phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= 1'b0;
        end else if (a) begin
            phase <= ~phase;
        end
    end

endmodule

// File: rtl/token_window_counter.sv
// Counts '1' tokens over back-to-back windows of WINDOW cycles and offers each
// window total through a single-entry valid/ready holding register.
module token_window_counter
    import token_pkg::*;
#(
    parameter int WINDOW = DEFAULT_WINDOW,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input logic                   clk,
    input logic                   rst,
    token_window_counter_if.slave bus
);

    localparam int CYC_W = $clog2(WINDOW);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WINDOW - 1);

    state_t           state;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] tok_cnt;
    logic [CNT_W-1:0] out_count;
    logic             out_valid;
    logic             overflow;

    logic             window_end;
    logic             slot_free;
    logic [CNT_W-1:0] total;

    assign window_end = (state == COUNT) && (cyc_cnt == LAST_CYC);
    assign slot_free  = !out_valid || bus.out_ready;
    // tok_cnt is at most WINDOW-1 here, so total never exceeds WINDOW.
    assign total      = tok_cnt + {{(CNT_W-1){1'b0}}, bus.a};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            tok_cnt   <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // A handshake empties the slot; a same-cycle load below re-fills it.
            if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cyc_cnt <= '0;
                    tok_cnt <= '0;
                    if (bus.start) begin
                        state <= COUNT;
                    end
                end

                COUNT: begin
                    if (bus.stop) begin
                        state   <= IDLE;
                        cyc_cnt <= '0;
                        tok_cnt <= '0;
                    end else if (window_end) begin
                        cyc_cnt <= '0;
                        tok_cnt <= '0;
                        if (slot_free) begin
                            out_count <= total;
                            out_valid <= 1'b1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                        tok_cnt <= total;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_count = out_count;
    assign bus.out_valid = out_valid;
    assign bus.overflow  = overflow;
    assign bus.state     = state;

endmodule

// File: tb/tb_token_window_counter.sv
// Directed bench for token_window_counter: an 8-cycle instance for window,
// backpressure and stop/reset cases, and a 16-cycle instance fed by halve_tokens.
module tb_token_window_counter;
    import token_pkg::*;

    localparam int CW8  = $clog2(8 + 1);
    localparam int CW16 = $clog2(16 + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // ---------------- DUTs ----------------
    token_window_counter_if #(.CNT_W(CW8))  bus8 ();
    token_window_counter_if #(.CNT_W(CW16)) bus16 ();

    logic a16_raw;
    logic half16;

    token_window_counter #(.WINDOW(8), .CNT_W(CW8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    halve_tokens u_half (
        .clk  (clk),
        .rst  (rst),
        .a    (a16_raw),
        .half (half16)
    );

    assign bus16.a = half16;

    token_window_counter #(.WINDOW(16), .CNT_W(CW16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;

    logic [CW8-1:0]  exp_q[$];
    int              exp_cyc_q[$];
    logic [CW16-1:0] exp16_q[$];
    int              exp16_cyc_q[$];

    logic [CW8-1:0]  e8;
    logic [CW16-1:0] e16;
    int              ec8;
    int              ec16;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus8.out_valid && bus8.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL dut8_unexpected: got out_count=%0d, expected no result (cycle %0d)",
                         bus8.out_count, cyc);
            end else begin
                e8  = exp_q.pop_front();
                ec8 = exp_cyc_q.pop_front();
                check("dut8_count", int'(bus8.out_count), int'(e8));
                check("dut8_cycle", cyc, ec8);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus16.out_valid && bus16.out_ready) begin
            if (exp16_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL dut16_unexpected: got out_count=%0d, expected no result (cycle %0d)",
                         bus16.out_count, cyc);
            end else begin
                e16  = exp16_q.pop_front();
                ec16 = exp16_cyc_q.pop_front();
                check("dut16_count", int'(bus16.out_count), int'(e16));
                check("dut16_cycle", cyc, ec16);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake expected at the negedge following the current cycle.
    task automatic expect8(input int v);
        exp_q.push_back(CW8'(v));
        exp_cyc_q.push_back(cyc);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
    endtask

    task automatic stop_now();
        bus8.stop = 1'b1;
        bus8.a    = 1'b0;
        tick();
        bus8.stop = 1'b0;
    endtask

    // Feeds bits[n-1] first, down to bits[0].
    task automatic run_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus8.a = bits[i];
            tick();
        end
        bus8.a = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] chain_bits;

    initial begin
        bus8.a = 1'b0;  bus8.start = 1'b0;  bus8.stop = 1'b0;  bus8.out_ready = 1'b1;
        bus16.start = 1'b0;  bus16.stop = 1'b0;  bus16.out_ready = 1'b1;
        a16_raw = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_state",     int'(bus8.state), int'(IDLE));
        check("rst_out_count", int'(bus8.out_count), 0);
        check("rst_out_valid", int'(bus8.out_valid), 0);
        check("rst_overflow",  int'(bus8.overflow), 0);
        check("rst16_valid",   int'(bus16.out_valid), 0);
        rst = 1'b0;
        tick();

        // Basic window: 1,1,0,1,0,0,1,1 -> 5
        do_start();
        check("basic_state", int'(bus8.state), int'(COUNT));
        run_bits(16'b1101_0011, 8);
        expect8(5);
        check("basic_valid", int'(bus8.out_valid), 1);
        stop_now();
        check("basic_valid_drop", int'(bus8.out_valid), 0);
        check("basic_overflow",   int'(bus8.overflow), 0);
        check("basic_idle",       int'(bus8.state), int'(IDLE));

        // Back-to-back all-ones windows -> 8, 8, 8 spaced 8 cycles apart
        do_start();
        for (int w = 0; w < 3; w++) begin
            run_bits(16'hFF, 8);
            expect8(8);
        end
        stop_now();
        check("b2b_overflow", int'(bus8.overflow), 0);

        // Backpressure: 3 held, 6 dropped, then drain and a normal window of 4
        bus8.out_ready = 1'b0;
        do_start();
        run_bits(16'b1110_0000, 8);
        check("bp_held_valid", int'(bus8.out_valid), 1);
        check("bp_held_count", int'(bus8.out_count), 3);
        run_bits(16'b0111_1110, 8);
        check("bp_keep_count", int'(bus8.out_count), 3);
        check("bp_overflow",   int'(bus8.overflow), 1);
        bus8.out_ready = 1'b1;
        expect8(3);
        bus8.a = 1'b1;
        tick();
        check("bp_drained", int'(bus8.out_valid), 0);
        run_bits(16'b0100101, 7);
        expect8(4);
        stop_now();
        check("bp_ovf_sticky", int'(bus8.overflow), 1);
        reset_dut();
        check("bp_ovf_rst", int'(bus8.overflow), 0);

        // Handshake of 2 on the same cycle as the window end of 7
        bus8.out_ready = 1'b0;
        do_start();
        run_bits(16'b1000_0001, 8);
        check("sim_held", int'(bus8.out_count), 2);
        run_bits(16'b1110111, 7);
        expect8(2);
        bus8.out_ready = 1'b1;
        bus8.a = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        bus8.a = 1'b0;
        check("sim_count",    int'(bus8.out_count), 7);
        check("sim_valid",    int'(bus8.out_valid), 1);
        check("sim_overflow", int'(bus8.overflow), 0);
        stop_now();
        tick();
        check("sim_persist_valid", int'(bus8.out_valid), 1);
        check("sim_persist_count", int'(bus8.out_count), 7);
        bus8.out_ready = 1'b1;
        expect8(7);
        tick();
        check("sim_accepted", int'(bus8.out_valid), 0);

        // Stop on cycle 5: no result, a ignored in IDLE
        do_start();
        run_bits(16'h1F, 5);
        bus8.stop = 1'b1;
        bus8.a = 1'b1;
        tick();
        bus8.stop = 1'b0;
        check("stop5_idle", int'(bus8.state), int'(IDLE));
        run_bits(16'h3FF, 10);
        check("stop5_valid", int'(bus8.out_valid), 0);

        // Stop on the window-end cycle: stop wins
        do_start();
        run_bits(16'h7F, 7);
        bus8.stop = 1'b1;
        bus8.a = 1'b1;
        tick();
        bus8.stop = 1'b0;
        bus8.a = 1'b0;
        check("stopend_valid",    int'(bus8.out_valid), 0);
        check("stopend_overflow", int'(bus8.overflow), 0);
        check("stopend_idle",     int'(bus8.state), int'(IDLE));
        tick();

        // start pulse inside COUNT leaves window timing unchanged: 1,0,1,1,0,1,1,0 -> 5
        do_start();
        run_bits(16'b101, 3);
        bus8.start = 1'b1;
        bus8.a = 1'b1;
        tick();
        bus8.start = 1'b0;
        check("restart_state", int'(bus8.state), int'(COUNT));
        run_bits(16'b0110, 4);
        expect8(5);
        stop_now();

        // Reset mid-window with a pending result and overflow set
        bus8.out_ready = 1'b0;
        do_start();
        run_bits(16'hFF, 8);
        run_bits(16'h01, 8);
        check("rstmid_full_window", int'(bus8.out_count), 8);
        check("rstmid_overflow",    int'(bus8.overflow), 1);
        run_bits(16'b111, 3);
        reset_dut();
        check("rstmid_valid",    int'(bus8.out_valid), 0);
        check("rstmid_count",    int'(bus8.out_count), 0);
        check("rstmid_overflow0", int'(bus8.overflow), 0);
        check("rstmid_state",    int'(bus8.state), int'(IDLE));
        bus8.out_ready = 1'b1;
        do_start();
        run_bits(16'b0000_0011, 8);
        expect8(2);
        stop_now();

        // Chained: 110_011_101_000_1111 through halve_tokens, WINDOW=16 -> 5
        chain_bits = 16'b1100_1110_1000_1111;
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            a16_raw = chain_bits[i];
            tick();
        end
        a16_raw = 1'b0;
        exp16_q.push_back(CW16'(5));
        exp16_cyc_q.push_back(cyc);
        bus16.stop = 1'b1;
        tick();
        bus16.stop = 1'b0;
        check("chain_valid_done", int'(bus16.out_valid), 0);

        tick();
        tick();
        check("drain8",  exp_q.size(), 0);
        check("drain16", exp16_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
